bounce_box_render: RTL and testbench
====================================

// Module: bounce_box_render
// PURPOSE
// - Pixel-generation stage directly downstream of the 480p display timing generator.
// - Consumes sx/sy/hsync/vsync/enable and emits 12-bit RGB plus re-aligned sync and data-enable.
// - Draws a solid box on a flat background; the box moves SPEED px/frame and bounces off the edges.
// - Box position updates only once per frame, during vertical blanking, so no tearing.
// PARAMETERS
// - H_RES      640     active pixels per line
// - V_RES      480     active lines per frame
// - BOX_SIZE   32      box width and height, px
// - SPEED      2       px moved per frame on each axis; 1 <= SPEED < BOX_SIZE
// - BOX_COLOR  12'hF80 RGB444 colour of the box
// - BG_COLOR   12'h136 RGB444 colour of the background
// PORTS
// - clk_pix   in   1   pixel clock, 25.2 MHz
// - rst       in   1   synchronous reset, active-high
// - sx        in   10  horizontal position from timing stage
// - sy        in   10  vertical position from timing stage
// - hsync_in  in   1   horizontal sync, active-low
// - vsync_in  in   1   vertical sync, active-low
// - de_in     in   1   data enable, high in the active area
// - pause     in   1   high = freeze box motion; must be synchronous to clk_pix
// - vga_r     out  4   red
// - vga_g     out  4   green
// - vga_b     out  4   blue
// - hsync     out  1   hsync_in delayed 2 cycles
// - vsync     out  1   vsync_in delayed 2 cycles
// - de        out  1   de_in delayed 2 cycles
// BEHAVIOUR
// - Reset is synchronous on rst, active-high; clock is clk_pix.
// - Reset values:
//   - vga_r/g/b = 0, de = 0, hsync = vsync = 1 (idle, negative polarity).
//   - Box state: bx = 0, by = 0, dir_x = +, dir_y = +.
//   - All pipeline registers are cleared.
// - Pipeline: fixed latency of 2 clk_pix cycles from all inputs to all outputs.
//   - Stage 1 registers sx, sy, de, hsync and vsync, and computes
//     in_box = (sx >= bx) && (sx < bx+BOX_SIZE) && (sy >= by) && (sy < by+BOX_SIZE).
//   - Stage 2 selects the colour and registers it together with the delayed syncs and de.
// - Colour selection:
//   - RGB = 0 whenever stage-1 de is low.
//   - Otherwise RGB = BOX_COLOR if in_box, else BG_COLOR.
// - Frame tick: a single-cycle pulse when (sy == V_RES && sx == 0), i.e. the first blanking line.
// - Motion on a frame tick with pause low, X axis (the Y axis is identical, using V_RES):
//   - Moving +: nx = bx + SPEED.
//     - If nx > H_RES - BOX_SIZE: bx <= H_RES - BOX_SIZE and dir_x flips to -.
//     - Otherwise bx <= nx.
//   - Moving -:
//     - If bx < SPEED: bx <= 0 and dir_x flips to +.
//     - Otherwise bx <= bx - SPEED.
//   - At a wall the box is clamped for one frame, then reverses.
// - Arithmetic: position compares and sums use 11-bit internal width, so bx + BOX_SIZE cannot wrap.
// - Boundary conditions:
//   - pause high on a tick: bx, by and both directions hold.
//   - pause is sampled only on the tick.
//   - rst and tick in the same cycle: reset wins.
//   - rst mid-frame: outputs return to their reset values on the next edge.
//   - After rst the pipeline refills within 2 cycles.
//   - Inputs with sx/sy beyond the active area but de_in high are rendered per the rules above.
// CONFIGURATION
// - Macro: BOUNCE_BORDER_EN.
// - When defined:
//   - A 1-px white frame (12'hFFF) is drawn where sx==0, sx==H_RES-1, sy==0 or sy==V_RES-1.
//   - The border has priority over the box and applies only while de is high.
//   - Its compare is done in stage 1, so latency stays 2.
// - When undefined: no border logic is present; the colour rules above apply unchanged.
// TESTING
// - Reset: rst high 3 cycles, then low -> de=0, hsync=vsync=1, RGB=0; first tick moves box to (2,2).
// - Latency, after reset with box at (0,0): de_in=1, sx=5, sy=5 -> 2 cycles later de=1, RGB=12'hF80.
//   Same with sx=40 -> RGB=12'h136.
// - Motion: 3 ticks -> box at (6,6).
//   Pixel (37,37) -> BOX_COLOR; pixel (38,37) -> BG_COLOR; pixel (5,10) -> BG_COLOR.
// - Right bounce: bx=606 moving + -> tick gives bx=608.
//   Next tick gives bx=608 with dir_x=-; next tick gives bx=606.
//   Same check at the bottom wall with by=446/448.
// - Pause/priority: pause=1 across 2 ticks -> bx, by unchanged.
//   rst=1 coincident with a tick -> bx=by=0.
// - BOUNCE_BORDER_EN: pixel (0,100) with de_in=1 -> RGB=12'hFFF.
//   Pixel (0,0) with box at (0,0) -> 12'hFFF.
//   Macro undefined, pixel (0,100) -> BG_COLOR.

Source files
------------

// File: rtl/bounce_box_if.sv
// bounce_box_if: video bus between the 480p timing generator and the pixel
// render stage. The timing side (master) drives position, syncs, data enable
// and the pause control. The render side (slave) returns RGB444 plus the
// re-aligned syncs and data enable.
interface bounce_box_if;
    logic [9:0] sx;
    logic [9:0] sy;
    logic       hsync_in;
    logic       vsync_in;
    logic       de_in;
    logic       pause;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;
    logic       hsync;
    logic       vsync;
    logic       de;

    modport master (
        output sx, sy, hsync_in, vsync_in, de_in, pause,
        input  vga_r, vga_g, vga_b, hsync, vsync, de
    );

    modport slave (
        input  sx, sy, hsync_in, vsync_in, de_in, pause,
        output vga_r, vga_g, vga_b, hsync, vsync, de
    );
endinterface

// File: rtl/bounce_box_render.sv
// bounce_box_render: pixel stage behind the 480p timing generator. It draws a
// solid box on a flat background. The box moves SPEED px per frame on each
// axis and bounces off the screen edges. The position is updated once per
// frame, on the first blanking line, so a frame is never drawn with two
// different box positions.
// Fixed latency of 2 clk_pix cycles from every input to every output.
// Optional feature: define BOUNCE_BORDER_EN to draw a 1-px white frame
// around the active area. The frame has priority over the box.
module bounce_box_render #(
    parameter int          H_RES     = 640,
    parameter int          V_RES     = 480,
    parameter int          BOX_SIZE  = 32,
    parameter int          SPEED     = 2,
    parameter logic [11:0] BOX_COLOR = 12'hF80,
    parameter logic [11:0] BG_COLOR  = 12'h136
) (
    input  logic        clk_pix,
    input  logic        rst,
    bounce_box_if.slave vid
);

    typedef enum logic {DIR_POS = 1'b0, DIR_NEG = 1'b1} dir_e;

    // Position and direction of one axis. 11 bits wide, so pos + BOX_SIZE
    // cannot wrap.
    typedef struct packed {
        logic [10:0] pos;
        dir_e        dir;
    } axis_t;

    localparam logic [10:0] X_MAX  = 11'(H_RES - BOX_SIZE);
    localparam logic [10:0] Y_MAX  = 11'(V_RES - BOX_SIZE);
    localparam logic [10:0] SPD    = 11'(SPEED);
    localparam logic [10:0] BOX    = 11'(BOX_SIZE);
    localparam logic [9:0]  V_TICK = 10'(V_RES);
    localparam axis_t       AXIS_RESET = '{pos: '0, dir: DIR_POS};

    // Advance one axis by SPEED. On reaching a wall the position is clamped
    // to the wall, and the direction flips only when the next step would
    // overshoot the wall.
    function automatic axis_t step_axis(input axis_t cur, input logic [10:0] lim);
        axis_t       nxt;
        logic [10:0] sum;
        nxt = cur;
        sum = cur.pos + SPD;
        if (cur.dir == DIR_POS) begin
            if (sum > lim) begin
                nxt.pos = lim;
                nxt.dir = DIR_NEG;
            end else begin
                nxt.pos = sum;
            end
        end else begin
            if (cur.pos < SPD) begin
                nxt.pos = '0;
                nxt.dir = DIR_POS;
            end else begin
                nxt.pos = cur.pos - SPD;
            end
        end
        return nxt;
    endfunction

    axis_t       axis_x_q, axis_x_d;
    axis_t       axis_y_q, axis_y_d;
    logic        frame_tick;
    logic [10:0] sx_w, sy_w;
    logic        in_box;

    logic        in_box_q, de1_q, hs1_q, vs1_q;
    logic [11:0] rgb_d, rgb_q;
    logic        de2_q, hs2_q, vs2_q;

    assign frame_tick = (vid.sy == V_TICK) && (vid.sx == 10'd0);
    assign sx_w       = {1'b0, vid.sx};
    assign sy_w       = {1'b0, vid.sy};
    assign in_box     = (sx_w >= axis_x_q.pos) && (sx_w < axis_x_q.pos + BOX) &&
                        (sy_w >= axis_y_q.pos) && (sy_w < axis_y_q.pos + BOX);

`ifdef BOUNCE_BORDER_EN
    logic border;
    logic border_q;
    assign border = (vid.sx == 10'd0) || (vid.sx == 10'(H_RES - 1)) ||
                    (vid.sy == 10'd0) || (vid.sy == 10'(V_RES - 1));
`endif

    // Next box state: move on the frame tick unless paused.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        axis_x_d = axis_x_q;
        axis_y_d = axis_y_q;
        if (frame_tick && !vid.pause) begin
            axis_x_d = step_axis(axis_x_q, X_MAX);
            axis_y_d = step_axis(axis_y_q, Y_MAX);
        end
    end

    // Box state register. Reset overrides a coincident tick.
    always_ff @(posedge clk_pix) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples values from before this clock edge.
        if (rst) begin
            axis_x_q <= AXIS_RESET;
            axis_y_q <= AXIS_RESET;
        end else begin
            axis_x_q <= axis_x_d;
            axis_y_q <= axis_y_d;
        end
    end

    // Stage 1: register the box hit test, data enable and syncs.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            in_box_q <= 1'b0;
            de1_q    <= 1'b0;
            hs1_q    <= 1'b1;
            vs1_q    <= 1'b1;
        end else begin
            in_box_q <= in_box;
            de1_q    <= vid.de_in;
            hs1_q    <= vid.hsync_in;
            vs1_q    <= vid.vsync_in;
        end
    end

`ifdef BOUNCE_BORDER_EN
    // Stage 1 border compare, kept in the same stage so latency stays 2.
    always_ff @(posedge clk_pix) begin
        if (rst) border_q <= 1'b0;
        else     border_q <= border;
    end
`endif

    // Colour select from the stage-1 flags. Blanking forces black.
    always_comb begin
        rgb_d = 12'h000;
        if (de1_q) begin
`ifdef BOUNCE_BORDER_EN
            if (border_q)      rgb_d = 12'hFFF;
            else if (in_box_q) rgb_d = BOX_COLOR;
            else               rgb_d = BG_COLOR;
`else
            rgb_d = in_box_q ? BOX_COLOR : BG_COLOR;
`endif
        end
    end

    // Stage 2: register the colour together with the delayed syncs and de.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            rgb_q <= 12'h000;
            de2_q <= 1'b0;
            hs2_q <= 1'b1;
            vs2_q <= 1'b1;
        end else begin
            rgb_q <= rgb_d;
            de2_q <= de1_q;
            hs2_q <= hs1_q;
            vs2_q <= vs1_q;
        end
    end

    assign vid.vga_r = rgb_q[11:8];
    assign vid.vga_g = rgb_q[7:4];
    assign vid.vga_b = rgb_q[3:0];
    assign vid.de    = de2_q;
    assign vid.hsync = hs2_q;
    assign vid.vsync = vs2_q;

endmodule

// File: tb/tb_bounce_box_render.sv
// tb_bounce_box_render: directed bench for bounce_box_render. A vector table
// covers the 2-cycle pipeline with the box at (0,0). Hand-written sequences
// cover reset, motion, wall bounces, pause and reset/tick priority.
// Define BOUNCE_BORDER_EN on both bench and RTL to check the border build.
module tb_bounce_box_render;

    localparam logic [11:0] BOX_C = 12'hF80;
    localparam logic [11:0] BG_C  = 12'h136;
`ifdef BOUNCE_BORDER_EN
    localparam logic [11:0] EDGE_C   = 12'hFFF;
    localparam logic [11:0] CORNER_C = 12'hFFF;
`else
    localparam logic [11:0] EDGE_C   = BG_C;
    localparam logic [11:0] CORNER_C = BOX_C;
`endif

    typedef struct packed {
        logic [9:0]  sx;
        logic [9:0]  sy;
        logic        de;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
        logic        de_o;
        logic        hs_o;
        logic        vs_o;
    } vec_t;

    logic clk_pix = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t vecs[14];
    logic [14:0] got;

    bounce_box_if vid();

    bounce_box_render dut (
        .clk_pix (clk_pix),
        .rst     (rst),
        .vid     (vid)
    );

    always #20 clk_pix = ~clk_pix;

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got rgb=%h de=%b hs=%b vs=%b, expected rgb=%h de=%b hs=%b vs=%b",
                     name, act[14:3], act[2], act[1], act[0], exp[14:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic idle();
        vid.sx       = 10'd700;
        vid.sy       = 10'd500;
        vid.de_in    = 1'b0;
        vid.hsync_in = 1'b1;
        vid.vsync_in = 1'b1;
    endtask

    function automatic logic [14:0] outs();
        return {vid.vga_r, vid.vga_g, vid.vga_b, vid.de, vid.hsync, vid.vsync};
    endfunction

    // Present one pixel for one cycle, then read it back 2 edges later.
    task automatic pixel(input logic [9:0] x, input logic [9:0] y, input logic de,
                         input logic hs, input logic vs, output logic [14:0] res);
        vid.sx       = x;
        vid.sy       = y;
        vid.de_in    = de;
        vid.hsync_in = hs;
        vid.vsync_in = vs;
        @(posedge clk_pix); #1;
        idle();
        @(posedge clk_pix); #1;
        res = outs();
    endtask

    task automatic check_px(input string name, input int x, input int y, input logic [11:0] exp);
        logic [14:0] r;
        pixel(10'(x), 10'(y), 1'b1, 1'b1, 1'b1, r);
        check($sformatf("%s(%0d,%0d)", name, x, y), r, {exp, 3'b111});
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            vid.sx    = 10'd0;
            vid.sy    = 10'd480;
            vid.de_in = 1'b0;
            @(posedge clk_pix); #1;
            idle();
        end
    endtask

    // Box with top-left corner at (x,y): inside near both corners, outside
    // just past each edge. The samples avoid the border rows/columns.
    task automatic probe_box(input string name, input int x, input int y);
        check_px({name, "_in_tl"}, x + 1, y + 1, BOX_C);
        check_px({name, "_in_br"}, x + 30, y + 30, BOX_C);
        check_px({name, "_out_r"}, x + 32, y + 1, BG_C);
        check_px({name, "_out_b"}, x + 1, y + 32, BG_C);
        if (x > 0) check_px({name, "_out_l"}, x - 1, y + 1, BG_C);
        if (y > 0) check_px({name, "_out_t"}, x + 1, y - 1, BG_C);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{10'd5,   10'd5,   1'b1, 1'b1, 1'b1, BOX_C,    1'b1, 1'b1, 1'b1};
        vecs[1]  = '{10'd40,  10'd5,   1'b1, 1'b1, 1'b1, BG_C,     1'b1, 1'b1, 1'b1};
        vecs[2]  = '{10'd31,  10'd31,  1'b1, 1'b1, 1'b1, BOX_C,    1'b1, 1'b1, 1'b1};
        vecs[3]  = '{10'd32,  10'd31,  1'b1, 1'b1, 1'b1, BG_C,     1'b1, 1'b1, 1'b1};
        vecs[4]  = '{10'd31,  10'd32,  1'b1, 1'b1, 1'b1, BG_C,     1'b1, 1'b1, 1'b1};
        vecs[5]  = '{10'd5,   10'd5,   1'b0, 1'b1, 1'b1, 12'h000,  1'b0, 1'b1, 1'b1};
        vecs[6]  = '{10'd5,   10'd5,   1'b1, 1'b0, 1'b1, BOX_C,    1'b1, 1'b0, 1'b1};
        vecs[7]  = '{10'd700, 10'd5,   1'b0, 1'b1, 1'b0, 12'h000,  1'b0, 1'b1, 1'b0};
        vecs[8]  = '{10'd0,   10'd100, 1'b1, 1'b1, 1'b1, EDGE_C,   1'b1, 1'b1, 1'b1};
        vecs[9]  = '{10'd0,   10'd0,   1'b1, 1'b1, 1'b1, CORNER_C, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{10'd639, 10'd5,   1'b1, 1'b1, 1'b1, EDGE_C,   1'b1, 1'b1, 1'b1};
        vecs[11] = '{10'd700, 10'd5,   1'b1, 1'b1, 1'b1, BG_C,     1'b1, 1'b1, 1'b1};
        vecs[12] = '{10'd5,   10'd479, 1'b1, 1'b1, 1'b1, EDGE_C,   1'b1, 1'b1, 1'b1};
        vecs[13] = '{10'd0,   10'd100, 1'b0, 1'b1, 1'b1, 12'h000,  1'b0, 1'b1, 1'b1};

        // Reset held 3 cycles while the inputs are active.
        rst          = 1'b1;
        vid.pause    = 1'b0;
        vid.sx       = 10'd5;
        vid.sy       = 10'd5;
        vid.de_in    = 1'b1;
        vid.hsync_in = 1'b0;
        vid.vsync_in = 1'b0;
        repeat (3) @(posedge clk_pix);
        #1;
        check("reset_hold", outs(), {12'h000, 3'b011});
        rst = 1'b0;
        idle();
        @(posedge clk_pix); #1;
        check("reset_release", outs(), {12'h000, 3'b011});

        // Vector table, box at (0,0).
        for (int i = 0; i < 14; i++) begin
            pixel(vecs[i].sx, vecs[i].sy, vecs[i].de, vecs[i].hs, vecs[i].vs, got);
            check($sformatf("vec%0d", i), got, {vecs[i].rgb, vecs[i].de_o, vecs[i].hs_o, vecs[i].vs_o});
        end

        // Motion: first tick reaches (2,2), three ticks reach (6,6).
        tick_n(1);
        probe_box("t1", 2, 2);
        tick_n(2);
        check_px("t3_box", 37, 37, BOX_C);
        check_px("t3_bg_x", 38, 37, BG_C);
        check_px("t3_bg_y", 5, 10, BG_C);

        // Pause across two ticks holds the box.
        vid.pause = 1'b1;
        tick_n(2);
        vid.pause = 1'b0;
        probe_box("pause", 6, 6);

        // Bottom wall: by 446 -> 448 -> 448 (flip) -> 446. X still climbing.
        tick_n(220);
        probe_box("k223", 446, 446);
        tick_n(1);
        probe_box("k224", 448, 448);
        tick_n(1);
        probe_box("k225", 450, 448);
        tick_n(1);
        probe_box("k226", 452, 446);

        // Right wall: bx 606 -> 608 -> 608 (flip) -> 606. Y descending.
        tick_n(77);
        probe_box("k303", 606, 292);
        tick_n(1);
        probe_box("k304", 608, 290);
        tick_n(1);
        probe_box("k305", 608, 288);
        tick_n(1);
        probe_box("k306", 606, 286);

        // Reset coincident with a tick: reset wins, box back at (0,0).
        vid.sx = 10'd0;
        vid.sy = 10'd480;
        rst    = 1'b1;
        @(posedge clk_pix); #1;
        rst = 1'b0;
        idle();
        probe_box("rst_tick", 0, 0);
        tick_n(1);
        probe_box("after_rst_tick", 2, 2);

        // Reset mid-frame with a box pixel in flight.
        vid.sx       = 10'd5;
        vid.sy       = 10'd5;
        vid.de_in    = 1'b1;
        vid.hsync_in = 1'b0;
        @(posedge clk_pix); #1;
        rst = 1'b1;
        @(posedge clk_pix); #1;
        check("rst_mid_frame", outs(), {12'h000, 3'b011});
        rst = 1'b0;
        idle();
        check_px("refill", 5, 5, BOX_C);
        check_px("refill_origin", 1, 1, BOX_C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
